// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   One digit is driven per slot. Each slot starts with a blanking gap (all
//   outputs off) to stop ghosting, followed by a drive phase that is PWM-dimmed
//   from a brightness code. New patterns and brightness are captured into
//   pending registers on 'load' and only become active at a frame boundary,
//   so a frame is never drawn with a mix of old and new data.
//
// Ports
//   clk             clock
//   reset           synchronous, active-low
//   enable          1 = scan, 0 = display dark and controller parked in IDLE
//   load            1-cycle pulse, captures digit_data/brightness as pending
//   digit_data      digit i in bits [8i+7:8i]; bit7 dp, bits6..0 g..a; 1 = lit
//   brightness      on-duty code for the PWM, 0 = dark
//   SevenSegment    cathodes, active-low, registered
//   SegmentDrivers  anodes, active-low, registered
//   digit_idx       index of the slot currently shown, registered
//   frame_done      1-cycle pulse at the end of the last digit slot
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int SLOT_CYCLES  = 12500,
   parameter int BLANK_CYCLES = 256,
   parameter int PWM_BITS     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          load,
   input  logic [8*NUM_DIGITS-1:0]       digit_data,
   input  logic [PWM_BITS-1:0]           brightness,
   output logic [7:0]                    SevenSegment,
   output logic [NUM_DIGITS-1:0]         SegmentDrivers,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(SLOT_CYCLES);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    slot_cnt, slot_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_d;
   logic [IDX_W-1:0]    slot_idx, slot_idx_d;
   logic                frame_start;
   logic                frame_end;

   logic [7:0]          pending_pat [NUM_DIGITS];
   logic [7:0]          active_pat  [NUM_DIGITS];
   logic [PWM_BITS-1:0] pending_bright;
   logic [PWM_BITS-1:0] active_bright;

   logic                lit;
   logic [7:0]          seg_d;
   logic [NUM_DIGITS-1:0] drv_d;
   logic [IDX_W-1:0]    idx_d;

   // Next-state logic for the scan FSM and its counters. Dropping enable
   // parks everything in IDLE with the counters and digit index cleared.
   // frame_start marks the cycle on which pending data moves to active:
   // leaving IDLE, or wrapping from the last digit back to digit 0.
   // The slot counter runs across the whole slot, so BLANK hands over to
   // DRIVE with the count already at BLANK_CYCLES.
   always_comb begin
      state_d     = state;
      slot_cnt_d  = slot_cnt;
      pwm_cnt_d   = pwm_cnt;
      slot_idx_d  = slot_idx;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      if (!enable) begin
         state_d    = IDLE;
         slot_cnt_d = '0;
         pwm_cnt_d  = '0;
         slot_idx_d = '0;
      end else begin
         case (state)
            IDLE: begin
               state_d     = BLANK;
               slot_cnt_d  = '0;
               pwm_cnt_d   = '0;
               slot_idx_d  = '0;
               frame_start = 1'b1;
            end
            BLANK: begin
               slot_cnt_d = slot_cnt + CNT_W'(1);
               if (slot_cnt == BLANK_LAST) begin
                  state_d   = DRIVE;
                  pwm_cnt_d = '0;
               end
            end
            DRIVE: begin
               pwm_cnt_d = pwm_cnt + PWM_BITS'(1);
               if (slot_cnt == SLOT_LAST) begin
                  state_d    = BLANK;
                  slot_cnt_d = '0;
                  if (slot_idx == DIGIT_LAST) begin
                     slot_idx_d  = '0;
                     frame_start = 1'b1;
                     frame_end   = 1'b1;
                  end else begin
                     slot_idx_d = slot_idx + IDX_W'(1);
                  end
               end else begin
                  slot_cnt_d = slot_cnt + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output decode, registered below. A digit is lit only in DRIVE while the
   // PWM count is below the active brightness; otherwise every anode and
   // cathode is off. Gating with enable makes the display go dark on the
   // very next cycle after enable drops, even though the FSM is mid-slot.
   always_comb begin
      lit   = enable && (state == DRIVE) && (pwm_cnt < active_bright);
      seg_d = 8'hFF;
      drv_d = '1;
      idx_d = enable ? slot_idx : '0;
      if (lit) begin
         seg_d = ~active_pat[slot_idx];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (lit && (slot_idx == IDX_W'(i))) begin
            drv_d[i] = 1'b0;
         end
      end
   end

   // Scan state and counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         slot_cnt <= '0;
         pwm_cnt  <= '0;
         slot_idx <= '0;
      end else begin
         state    <= state_d;
         slot_cnt <= slot_cnt_d;
         pwm_cnt  <= pwm_cnt_d;
         slot_idx <= slot_idx_d;
      end
   end

   // Pending and active display data. A load always lands in pending; the
   // active copy is refreshed only at frame start. Because both update on
   // the same edge, a load on the frame-start cycle itself is picked up at
   // the following frame. Reset wins over a simultaneous load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            pending_pat[i] <= '0;
            active_pat[i]  <= '0;
         end
         pending_bright <= '0;
         active_bright  <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               pending_pat[i] <= digit_data[8*i +: 8];
            end
            pending_bright <= brightness;
         end
         if (frame_start) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               active_pat[i] <= pending_pat[i];
            end
            active_bright <= pending_bright;
         end
      end
   end

   // Registered outputs, one cycle behind the state and counters they
   // decode.
   always_ff @(posedge clk) begin
      if (!reset) begin
         SevenSegment   <= 8'hFF;
         SegmentDrivers <= '1;
         digit_idx      <= '0;
         frame_done     <= 1'b0;
      end else begin
         SevenSegment   <= seg_d;
         SegmentDrivers <= drv_d;
         digit_idx      <= idx_d;
         frame_done     <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with a small scan (4 digits, 20-cycle
//   slots, 4 blank cycles, 4-bit PWM). A frame-position model predicts the
//   outputs for each driven cycle; predictions are queued when stimulus is
//   applied and compared after the following clock edge.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int SLOT  = 20;
   localparam int BLANK = 4;
   localparam int FRAME = N * SLOT;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load;
   logic [31:0] digit_data;
   logic [3:0]  brightness;
   logic [7:0]  SevenSegment;
   logic [3:0]  SegmentDrivers;
   logic [1:0]  digit_idx;
   logic        frame_done;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] drv;
      logic [1:0] idx;
      logic       done;
   } exp_t;

   exp_t exp_q[$];

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: frame position of the cycle being driven.
   bit         m_run;
   int         m_pos;
   logic [7:0] m_pend_pat [N];
   logic [7:0] m_act_pat  [N];
   int         m_pend_br;
   int         m_act_br;

   seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK),
      .PWM_BITS     (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .load           (load),
      .digit_data     (digit_data),
      .brightness     (brightness),
      .SevenSegment   (SevenSegment),
      .SegmentDrivers (SegmentDrivers),
      .digit_idx      (digit_idx),
      .frame_done     (frame_done)
   );

   // Free-running 100 MHz-style clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the outputs they should produce after
   // the next edge, then advance the model across that edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                input logic [31:0] data, input logic [3:0] br);
      exp_t       e;
      int         slot;
      int         off;
      logic [3:0] onehot;
      logic [7:0] old_pat [N];
      int         old_br;
      reset      = rst;
      enable     = en;
      load       = ld;
      digit_data = data;
      brightness = br;
      e.seg  = 8'hFF;
      e.drv  = 4'hF;
      e.idx  = 2'd0;
      e.done = 1'b0;
      if (rst && en && m_run) begin
         slot   = m_pos / SLOT;
         off    = m_pos % SLOT;
         e.idx  = 2'(slot);
         e.done = (m_pos == FRAME - 1);
         if (off >= BLANK && (off - BLANK) < m_act_br) begin
            onehot = 4'b0001;
            onehot = onehot << slot;
            e.seg  = ~m_act_pat[slot];
            e.drv  = ~onehot;
         end
      end
      exp_q.push_back(e);
      for (int i = 0; i < N; i++) old_pat[i] = m_pend_pat[i];
      old_br = m_pend_br;
      if (!rst) begin
         m_run = 0;
         m_pos = 0;
         for (int i = 0; i < N; i++) begin
            m_pend_pat[i] = 8'h00;
            m_act_pat[i]  = 8'h00;
         end
         m_pend_br = 0;
         m_act_br  = 0;
      end else begin
         if (ld) begin
            for (int i = 0; i < N; i++) m_pend_pat[i] = data[8*i +: 8];
            m_pend_br = int'(br);
         end
         if (!en) begin
            m_run = 0;
            m_pos = 0;
         end else if (!m_run || m_pos == FRAME - 1) begin
            m_run = 1;
            m_pos = 0;
            for (int i = 0; i < N; i++) m_act_pat[i] = old_pat[i];
            m_act_br = old_br;
         end else begin
            m_pos++;
         end
      end
   endtask

   // Pop the prediction for the edge just taken and compare every output.
   task automatic checkOutput();
      exp_t e;
      vectors++;
      assert (exp_q.size() > 0) else begin
         miscompares++;
         $error("[TB] FAIL scoreboard_empty at %0t", $time);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         assert (SevenSegment === e.seg) else begin
            miscompares++;
            $error("[TB] FAIL SevenSegment at %0t: got %h expected %h", $time, SevenSegment, e.seg);
         end
         vectors++;
         assert (SegmentDrivers === e.drv) else begin
            miscompares++;
            $error("[TB] FAIL SegmentDrivers at %0t: got %b expected %b", $time, SegmentDrivers, e.drv);
         end
         vectors++;
         assert (digit_idx === e.idx) else begin
            miscompares++;
            $error("[TB] FAIL digit_idx at %0t: got %0d expected %0d", $time, digit_idx, e.idx);
         end
         vectors++;
         assert (frame_done === e.done) else begin
            miscompares++;
            $error("[TB] FAIL frame_done at %0t: got %b expected %b", $time, frame_done, e.done);
         end
      end
      vectors++;
      assert ($countones(~SegmentDrivers) <= 1) else begin
         miscompares++;
         $error("[TB] FAIL one_anode at %0t: got %b expected at most one low", $time, SegmentDrivers);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic ld,
                       input logic [31:0] data, input logic [3:0] br);
      @(negedge clk);
      applyStimulus(rst, en, ld, data, br);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
   endtask

   // Idle until the model reaches frame position 'target', bounded.
   task automatic waitPos(input int target);
      bit found;
      found = 0;
      for (int i = 0; i < 2 * FRAME + 2; i++) begin
         if (m_run && m_pos == target) begin
            found = 1;
            break;
         end
         step(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("[TB] FAIL wait_pos timeout: got none expected position %0d", target);
      end
   endtask

   initial begin
      m_run     = 0;
      m_pos     = 0;
      m_pend_br = 0;
      m_act_br  = 0;
      for (int i = 0; i < N; i++) begin
         m_pend_pat[i] = 8'h00;
         m_act_pat[i]  = 8'h00;
      end
      reset      = 1'b0;
      enable     = 1'b0;
      load       = 1'b0;
      digit_data = 32'h0;
      brightness = 4'h0;

      $display("[TB] reset held low for 3 cycles");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

      $display("[TB] scanning with zeroed data: dark, frame_done every frame");
      run(2 * FRAME + 5);

      $display("[TB] full brightness pattern");
      step(1'b1, 1'b1, 1'b1, 32'h3F065B4F, 4'd15);
      waitPos(0);
      run(2 * FRAME);

      $display("[TB] half brightness, then zero brightness");
      step(1'b1, 1'b1, 1'b1, 32'h3F065B4F, 4'd8);
      waitPos(0);
      run(FRAME + 3);
      step(1'b1, 1'b1, 1'b1, 32'h3F065B4F, 4'd0);
      waitPos(0);
      run(FRAME + 3);

      $display("[TB] load on frame-start cycle and mid-frame load");
      waitPos(FRAME - 1);
      step(1'b1, 1'b1, 1'b1, 32'h80FF7F01, 4'd15);
      run(FRAME - 1);
      waitPos(45);
      step(1'b1, 1'b1, 1'b1, 32'h6D7D0777, 4'd12);
      step(1'b1, 1'b1, 1'b1, 32'h11223344, 4'd15);
      run(2 * FRAME);

      $display("[TB] enable dropped during digit 1 drive");
      waitPos(30);
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
      run(FRAME + 10);

      $display("[TB] reset with simultaneous load mid-scan");
      waitPos(50);
      step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 4'd15);
      run(2 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
